// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART receiver and its TX successor.
// No ports: rx FSM state enum, parity encodings, baud divider helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int uart_div(
    input int clk,
    input int baud,
    input int ovs
  );
    return clk / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running divider emitting a 1-clk tick every DIV clocks.
// Ports: clk, rst (sync, active high), clr (sync re-zero), tick (out).
module uart_baud_tick #(
  parameter int DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: oversampled UART receiver, configurable frame, error pulses,
// storage with rx_rdy_clr as pop. Define UART_RX_FIFO_EN for a FIFO_DEPTH FIFO,
// otherwise a single holding register.
// Ports: clk, rst (sync, active high), rx_in, rx_rdy_clr in;
// rx_data_out, rx_rdy_out, rx_count, frame_err, parity_err, overrun out.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_in,
  input  logic                            rx_rdy_clr,
  output logic [DATA_BITS-1:0]            rx_data_out,
  output logic                            rx_rdy_out,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] rx_count,
  output logic                            frame_err,
  output logic                            parity_err,
  output logic                            overrun
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_FULL = TW'(OVERSAMPLE - 1);
  localparam logic [3:0] B_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] B_STOP = 4'(STOP_BITS - 1);

  rx_state_t state;
  logic sync1, sync2, prev;
  logic fall, start, tick, samp;
  logic [TW-1:0] tcnt;
  logic [3:0] bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic ferr_q, perr_q, done;
  logic ones_odd;
  logic [CW-1:0] count;
  logic full, pop, ok, push;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  // Only a genuine 1->0 transition starts a frame, so a line left low
  // after an error must rise again first.
  assign fall  = prev & ~sync2;
  assign start = (state == IDLE) & fall;

  uart_baud_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .clr (start),
    .tick(tick)
  );

  assign samp = tick && (state != IDLE) &&
                (tcnt == ((state == START) ? T_HALF : T_FULL));

  assign ones_odd = (^shreg) ^ sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      tcnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      ferr_q <= 1'b0;
      perr_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state <= START;
        tcnt  <= '0;
      end else if (samp) begin
        tcnt <= '0;
        case (state)
          START: begin
            if (sync2) begin
              state <= IDLE;
            end else begin
              state  <= DATA;
              bcnt   <= '0;
              ferr_q <= 1'b0;
              perr_q <= 1'b0;
            end
          end
          DATA: begin
            shreg <= {sync2, shreg[DATA_BITS-1:1]};
            if (bcnt == B_DATA) begin
              bcnt  <= '0;
              state <= (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          uart_pkg::PARITY: begin
            perr_q <= (PARITY == PAR_EVEN) ? ones_odd : ~ones_odd;
            state  <= STOP;
          end
          STOP: begin
            if (!sync2) ferr_q <= 1'b1;
            if (bcnt == B_STOP) begin
              bcnt  <= '0;
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (tick && state != IDLE) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  // Commit cycle: the cycle after the last stop sample (done high).
  assign pop        = rx_rdy_clr & (count != '0);
  assign ok         = done & ~ferr_q & ~perr_q;
  assign push       = ok & (~full | pop);
  assign frame_err  = done & ferr_q;
  assign parity_err = done & ~ferr_q & perr_q;
  assign overrun    = ok & full & ~pop;
  assign rx_count   = count;
  assign rx_rdy_out = (count != '0);

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [DATA_BITS-1:0] hold;

  assign full = (count == CW'(FIFO_DEPTH));
  assign rx_data_out = (count != '0) ? mem[rd_ptr] : hold;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        hold   <= mem[rd_ptr];
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end
`else
  logic [DATA_BITS-1:0] data_q;

  assign full = (count != '0);
  assign rx_data_out = data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        data_q <= shreg;
        count  <= CW'(1);
      end else if (pop) begin
        count <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: directed table, corner sequences and random frames
// for uart_rx_param (8E1), checked against a frame-level queue model.
module tb_uart_rx_param;

  localparam int CLK_FREQ = 640_000;
  localparam int BAUD = 10_000;
  localparam int OVS = 16;
  localparam int FD = 4;
  localparam int TICK = CLK_FREQ / (BAUD * OVS);
  localparam int BIT = TICK * OVS;
  localparam int CW = $clog2(FD + 1);
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = FD;
`else
  localparam int DEPTH = 1;
`endif

  typedef struct {
    logic [7:0] d;
    bit bp;
    bit bs;
    int efe;
    int epe;
    int ecnt;
    logic [7:0] ehead;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_in = 1'b1;
  logic rx_rdy_clr = 1'b0;
  logic [7:0] rx_data_out;
  logic rx_rdy_out;
  logic [CW-1:0] rx_count;
  logic frame_err, parity_err, overrun;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int pe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] q[$];
  logic [7:0] held = 8'h00;
  vec_t tbl[8];

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ),
    .BAUD_RATE(BAUD),
    .OVERSAMPLE(OVS),
    .DATA_BITS(8),
    .PARITY(2),
    .STOP_BITS(1),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_in(rx_in),
    .rx_rdy_clr(rx_rdy_clr),
    .rx_data_out(rx_data_out),
    .rx_rdy_out(rx_rdy_out),
    .rx_count(rx_count),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun)
  );

  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (parity_err) pe_cnt <= pe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input int n);
    rx_in = v;
    repeat (n) @(negedge clk);
  endtask

  // Even parity frame; bp flips the parity bit, bs drives the stop bit low.
  task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs);
    logic p;
    p = ^d;
    if (bp) p = ~p;
    drive(1'b0, BIT);
    for (int i = 0; i < 8; i++) drive(d[i], BIT);
    drive(p, BIT);
    drive(!bs, BIT);
    drive(1'b1, 2 * BIT);
  endtask

  task automatic frame_check(input logic [7:0] d, input bit bp, input bit bs);
    int f0, p0, o0, efe, epe, eov;
    f0 = fe_cnt;
    p0 = pe_cnt;
    o0 = ov_cnt;
    send_frame(d, bp, bs);
    efe = 0;
    epe = 0;
    eov = 0;
    if (bs) efe = 1;
    else if (bp) epe = 1;
    else if (q.size() == DEPTH) eov = 1;
    else q.push_back(d);
    check("frame_err", fe_cnt - f0, efe);
    check("parity_err", pe_cnt - p0, epe);
    check("overrun", ov_cnt - o0, eov);
    check("rx_count", rx_count, q.size());
    check("rx_rdy_out", rx_rdy_out, q.size() != 0);
    check("rx_data_out", rx_data_out, (q.size() != 0) ? q[0] : held);
  endtask

  task automatic pop_check();
    if (q.size() != 0) check("pop head", rx_data_out, q[0]);
    rx_rdy_clr = 1'b1;
    @(negedge clk);
    rx_rdy_clr = 1'b0;
    if (q.size() != 0) held = q.pop_front();
    check("pop count", rx_count, q.size());
    check("pop data", rx_data_out, (q.size() != 0) ? q[0] : held);
  endtask

  initial begin
    int f0, p0, o0;
    logic [7:0] v;
    tbl[0] = '{8'hA5, 0, 0, 0, 0, 1, 8'hA5};
    tbl[1] = '{8'hCB, 1, 0, 0, 1, 0, 8'hA5};
    tbl[2] = '{8'h5A, 0, 1, 1, 0, 0, 8'hA5};
    tbl[3] = '{8'hFF, 0, 0, 0, 0, 1, 8'hFF};
    tbl[4] = '{8'h5A, 1, 1, 1, 0, 0, 8'hFF};
    tbl[5] = '{8'h00, 0, 0, 0, 0, 1, 8'h00};
    tbl[6] = '{8'h81, 1, 0, 0, 1, 0, 8'h00};
    tbl[7] = '{8'h3C, 0, 0, 0, 0, 1, 8'h3C};

    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset rx_rdy_out", rx_rdy_out, 0);
    check("reset rx_count", rx_count, 0);
    check("reset rx_data_out", rx_data_out, 0);
    check("reset pulses", fe_cnt + pe_cnt + ov_cnt, 0);

    for (int i = 0; i < 8; i++) begin
      f0 = fe_cnt;
      p0 = pe_cnt;
      o0 = ov_cnt;
      send_frame(tbl[i].d, tbl[i].bp, tbl[i].bs);
      check("tbl frame_err", fe_cnt - f0, tbl[i].efe);
      check("tbl parity_err", pe_cnt - p0, tbl[i].epe);
      check("tbl overrun", ov_cnt - o0, 0);
      check("tbl rx_count", rx_count, tbl[i].ecnt);
      check("tbl rx_data_out", rx_data_out, tbl[i].ehead);
      if (tbl[i].ecnt != 0) begin
        rx_rdy_clr = 1'b1;
        @(negedge clk);
        rx_rdy_clr = 1'b0;
        check("tbl pop count", rx_count, 0);
      end
      check("tbl held data", rx_data_out, tbl[i].ehead);
      held = tbl[i].ehead;
    end

    // False start: low for 4 ticks only.
    f0 = fe_cnt;
    p0 = pe_cnt;
    o0 = ov_cnt;
    drive(1'b0, 4 * TICK);
    drive(1'b1, 3 * BIT);
    check("glitch pulses", (fe_cnt - f0) + (pe_cnt - p0) + (ov_cnt - o0), 0);
    check("glitch rx_count", rx_count, 0);
    frame_check(8'h3C, 0, 0);
    pop_check();

    // Fill storage, then one more frame overruns; pops come out in order.
    o0 = ov_cnt;
    for (int i = 0; i <= DEPTH; i++) frame_check(8'(8'h11 * i), 0, 0);
    check("overrun total", ov_cnt - o0, 1);
    check("full rx_count", rx_count, DEPTH);
    while (q.size() != 0) pop_check();
    pop_check();

    // Reset during data bit 3 of 0xE7 with a byte already held.
    frame_check(8'h96, 0, 0);
    f0 = fe_cnt;
    p0 = pe_cnt;
    o0 = ov_cnt;
    v = 8'hE7;
    drive(1'b0, BIT);
    for (int i = 0; i < 3; i++) drive(v[i], BIT);
    drive(v[3], BIT / 2);
    rst = 1'b1;
    rx_in = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    held = 8'h00;
    check("rst rx_rdy_out", rx_rdy_out, 0);
    check("rst rx_count", rx_count, 0);
    check("rst rx_data_out", rx_data_out, 0);
    drive(1'b1, 3 * BIT);
    check("rst pulses", (fe_cnt - f0) + (pe_cnt - p0) + (ov_cnt - o0), 0);
    frame_check(8'h3C, 0, 0);
    pop_check();

    for (int i = 0; i < 16; i++) begin
      frame_check(8'($urandom), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 1) pop_check();
    end
    while (q.size() != 0) pop_check();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
